// File: rtl/memory_bus_interface.sv
// memory_bus_interface: CPU byte/half/word load-store sequencer for a big-endian word RAM.
// Define MEMORY_BUS_ERROR_EN to trap misaligned, reserved-width and read+write requests.
module memory_bus_interface #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] cpu_address,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_signed,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_data_in,
  output logic [31:0] cpu_data_out,
  output logic        cpu_busy,
  output logic        cpu_done,
`ifdef MEMORY_BUS_ERROR_EN
  output logic        cpu_bus_error,
`endif
  output logic [29:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic [3:0]  mem_data_strobes,
  output logic        mem_read,
  output logic        mem_write
);
  typedef enum logic [2:0] {
    IDLE, READ, WRITE, DONE
`ifdef MEMORY_BUS_ERROR_EN
    , ERROR
`endif
  } state_t;
  state_t state, next;
  logic [31:0] addr_q, wdata_q, steered, loaded;
  logic [1:0]  width_q;
  logic        sgn_q, accept, last;
  logic [3:0]  cnt, wstrb;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
`ifdef MEMORY_BUS_ERROR_EN
  logic        bad;
  assign bad = (cpu_read & cpu_write) | (cpu_width == 2'b11) |
               ((cpu_width == 2'b01) & cpu_address[0]) |
               ((cpu_width == 2'b10) & |cpu_address[1:0]);
  assign cpu_bus_error = state == ERROR;
`endif
  always_comb begin
    next = state;
    case (state)
`ifdef MEMORY_BUS_ERROR_EN
      IDLE:    next = !(cpu_read | cpu_write) ? IDLE : bad ? ERROR : cpu_write ? WRITE : READ;
`else
      IDLE:    next = cpu_write ? WRITE : cpu_read ? READ : IDLE;
`endif
      READ:    next = last ? DONE : READ;
      WRITE:   next = DONE;
      default: next = IDLE;
    endcase
  end
  assign accept  = (state == IDLE) && (next == READ || next == WRITE);
  assign last    = cnt == 4'(WAIT_STATES);
  assign steered = cpu_width == 2'b00 ? {4{cpu_data_in[7:0]}} :
                   cpu_width == 2'b01 ? {2{cpu_data_in[15:0]}} : cpu_data_in;
  // Halfwords use only address bit 1 so an unaligned request is forced aligned.
  assign wstrb   = width_q == 2'b00 ? 4'b1000 >> addr_q[1:0] :
                   width_q == 2'b01 ? (addr_q[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign rd_byte = mem_data_in[{~addr_q[1:0], 3'b000} +: 8];
  assign rd_half = mem_data_in[{~addr_q[1], 4'b0000} +: 16];
  assign loaded  = width_q == 2'b00 ? {{24{sgn_q & rd_byte[7]}}, rd_byte} :
                   width_q == 2'b01 ? {{16{sgn_q & rd_half[15]}}, rd_half} : mem_data_in;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      width_q      <= '0;
      sgn_q        <= 1'b0;
      wdata_q      <= '0;
      cnt          <= '0;
      cpu_data_out <= '0;
    end else begin
      state <= next;
      cnt   <= (state == READ) ? cnt + 4'd1 : 4'd0;
      if (accept) begin
        addr_q  <= cpu_address;
        width_q <= cpu_width;
        sgn_q   <= cpu_signed;
        wdata_q <= steered;
      end
      if (state == READ && last) cpu_data_out <= loaded;
    end
  end
  assign cpu_busy         = state != IDLE;
  assign cpu_done         = state == DONE;
  assign mem_read         = state == READ;
  assign mem_write        = state == WRITE;
  assign mem_address      = addr_q[31:2];
  assign mem_data_out     = wdata_q;
  assign mem_data_strobes = state == WRITE ? wstrb : state == READ ? 4'b1111 : 4'b0000;
endmodule

// File: tb/tb_memory_bus_interface.sv
// tb_memory_bus_interface: directed checks of stores, extended loads, wait states and reset.
module tb_memory_bus_interface;
  logic clock = 0, reset_n = 0;
  always #5 clock = ~clock;
  logic [31:0] cpu_address = 0, cpu_data_in = 0;
  logic [1:0]  cpu_width = 0;
  logic        cpu_signed = 0, rd0 = 0, wr0 = 0, rd3 = 0, wr3 = 0;
  logic [31:0] dout0, dout3, mdo0, mdo3, mdi0, mdi3;
  logic [29:0] maddr0, maddr3;
  logic [3:0]  strb0, strb3;
  logic        busy0, busy3, done0, done3, mrd0, mrd3, mwr0, mwr3;
`ifdef MEMORY_BUS_ERROR_EN
  logic        berr0, berr3;
`endif
  logic [31:0] ram [32];
  int errors = 0, checks = 0;
  assign mdi0 = ram[maddr0[4:0]];
  assign mdi3 = ram[maddr3[4:0]];
  always @(negedge clock)
    if (mwr0) for (int i = 0; i < 4; i++) if (strb0[i]) ram[maddr0[4:0]][i*8 +: 8] <= mdo0[i*8 +: 8];

  memory_bus_interface #(.WAIT_STATES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_width(cpu_width),
    .cpu_signed(cpu_signed), .cpu_read(rd0), .cpu_write(wr0), .cpu_data_in(cpu_data_in),
    .cpu_data_out(dout0), .cpu_busy(busy0), .cpu_done(done0),
`ifdef MEMORY_BUS_ERROR_EN
    .cpu_bus_error(berr0),
`endif
    .mem_address(maddr0), .mem_data_out(mdo0), .mem_data_in(mdi0),
    .mem_data_strobes(strb0), .mem_read(mrd0), .mem_write(mwr0));

  memory_bus_interface #(.WAIT_STATES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_width(cpu_width),
    .cpu_signed(cpu_signed), .cpu_read(rd3), .cpu_write(wr3), .cpu_data_in(cpu_data_in),
    .cpu_data_out(dout3), .cpu_busy(busy3), .cpu_done(done3),
`ifdef MEMORY_BUS_ERROR_EN
    .cpu_bus_error(berr3),
`endif
    .mem_address(maddr3), .mem_data_out(mdo3), .mem_data_in(mdi3),
    .mem_data_strobes(strb3), .mem_read(mrd3), .mem_write(mwr3));

  task automatic start(input logic sel3, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [1:0] w, input logic s, input logic [31:0] d);
    @(negedge clock);
    cpu_address = a; cpu_width = w; cpu_signed = s; cpu_data_in = d;
    if (sel3) begin rd3 = rd; wr3 = wr; end else begin rd0 = rd; wr0 = wr; end
    @(posedge clock); #1;
    rd0 = 0; wr0 = 0; rd3 = 0; wr3 = 0;
  endtask

  task automatic finish0(output int cyc);
    cyc = 0;
    while (!done0 && cyc < 40) begin @(posedge clock); #1; cyc++; end
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset_n = 0;
    #12;
    checks++; if ({busy0, done0, mrd0, mwr0, strb0} !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", {busy0, done0, mrd0, mwr0, strb0}); end
    checks++; if (maddr0 !== 30'h0) begin errors++; $display("FAIL reset_addr got %h want 0", maddr0); end
    checks++; if (mdo0 !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mdo0); end
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", dout0); end
    @(negedge clock); reset_n = 1;
  endtask

  task automatic test_word;
    int cyc;
    start(0, 0, 1, 32'h10, 2'b10, 0, 32'h11223344);
    checks++; if ({mwr0, strb0} !== 5'b11111) begin errors++; $display("FAIL word_store_strb got %b want 11111", {mwr0, strb0}); end
    checks++; if (maddr0 !== 30'd4) begin errors++; $display("FAIL word_store_addr got %h want 4", maddr0); end
    checks++; if (mdo0 !== 32'h11223344) begin errors++; $display("FAIL word_store_data got %h want 11223344", mdo0); end
    finish0(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL store_done_latency got %0d want 1", cyc); end
    start(0, 1, 0, 32'h10, 2'b10, 0, 0);
    checks++; if ({mrd0, mwr0, strb0} !== 6'b101111) begin errors++; $display("FAIL word_load_ctrl got %b want 101111", {mrd0, mwr0, strb0}); end
    finish0(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL load_done_latency got %0d want 1", cyc); end
    checks++; if (dout0 !== 32'h11223344) begin errors++; $display("FAIL word_load got %h want 11223344", dout0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_after_done got %b want 0", busy0); end
  endtask

  task automatic test_byte;
    int cyc;
    start(0, 0, 1, 32'h21, 2'b00, 0, 32'h123456A5);
    checks++; if (strb0 !== 4'b0100) begin errors++; $display("FAIL byte_strb got %b want 0100", strb0); end
    checks++; if (mdo0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL byte_lanes got %h want a5a5a5a5", mdo0); end
    checks++; if (maddr0 !== 30'd8) begin errors++; $display("FAIL byte_addr got %h want 8", maddr0); end
    finish0(cyc);
    checks++; if (dout0 !== 32'h11223344) begin errors++; $display("FAIL store_keeps_dout got %h want 11223344", dout0); end
    start(0, 1, 0, 32'h21, 2'b00, 1, 0);
    finish0(cyc);
    checks++; if (dout0 !== 32'hFFFFFFA5) begin errors++; $display("FAIL byte_signed got %h want ffffffa5", dout0); end
    start(0, 1, 0, 32'h21, 2'b00, 0, 0);
    finish0(cyc);
    checks++; if (dout0 !== 32'h000000A5) begin errors++; $display("FAIL byte_unsigned got %h want 000000a5", dout0); end
  endtask

  task automatic test_half;
    int cyc;
    start(0, 0, 1, 32'h30, 2'b10, 0, 32'hDEADBEEF);
    finish0(cyc);
    start(0, 0, 1, 32'h32, 2'b01, 0, 32'h00008001);
    checks++; if (strb0 !== 4'b0011) begin errors++; $display("FAIL half_strb got %b want 0011", strb0); end
    checks++; if (mdo0 !== 32'h80018001) begin errors++; $display("FAIL half_lanes got %h want 80018001", mdo0); end
    finish0(cyc);
    start(0, 1, 0, 32'h32, 2'b01, 1, 0);
    finish0(cyc);
    checks++; if (dout0 !== 32'hFFFF8001) begin errors++; $display("FAIL half_signed got %h want ffff8001", dout0); end
    start(0, 1, 0, 32'h32, 2'b01, 0, 0);
    finish0(cyc);
    checks++; if (dout0 !== 32'h00008001) begin errors++; $display("FAIL half_unsigned got %h want 00008001", dout0); end
    start(0, 1, 0, 32'h30, 2'b01, 1, 0);
    finish0(cyc);
    checks++; if (dout0 !== 32'hFFFFDEAD) begin errors++; $display("FAIL half_upper got %h want ffffdead", dout0); end
    start(0, 1, 0, 32'h30, 2'b10, 0, 0);
    finish0(cyc);
    checks++; if (dout0 !== 32'hDEAD8001) begin errors++; $display("FAIL half_merge got %h want dead8001", dout0); end
  endtask

  task automatic test_wait_states;
    int nrd = 0, nbusy = 0, first = -1;
    start(1, 1, 0, 32'h10, 2'b10, 0, 0);
    for (int i = 0; i < 7; i++) begin
      nrd += int'(mrd3);
      nbusy += int'(busy3);
      if (done3 && first < 0) first = i;
      @(posedge clock); #1;
    end
    checks++; if (nrd !== 4) begin errors++; $display("FAIL ws_read_cycles got %0d want 4", nrd); end
    checks++; if (nbusy !== 5) begin errors++; $display("FAIL ws_busy_cycles got %0d want 5", nbusy); end
    checks++; if (first !== 4) begin errors++; $display("FAIL ws_done_cycle got %0d want 4", first); end
    checks++; if (dout3 !== 32'h11223344) begin errors++; $display("FAIL ws_data got %h want 11223344", dout3); end
  endtask

  task automatic test_misaligned;
    int cyc;
    start(0, 0, 1, 32'h40, 2'b10, 0, 32'hCAFEF00D);
    finish0(cyc);
    start(0, 1, 0, 32'h41, 2'b01, 0, 0);
`ifdef MEMORY_BUS_ERROR_EN
    checks++; if ({berr0, mrd0, mwr0, done0} !== 4'b1000) begin errors++; $display("FAIL err_pulse got %b want 1000", {berr0, mrd0, mwr0, done0}); end
    @(posedge clock); #1;
    checks++; if ({berr0, busy0, mrd0, mwr0, done0} !== 5'b0) begin errors++; $display("FAIL err_end got %b want 00000", {berr0, busy0, mrd0, mwr0, done0}); end
    checks++; if (dout0 !== 32'hDEAD8001) begin errors++; $display("FAIL err_keeps_dout got %h want dead8001", dout0); end
`else
    finish0(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL misaligned_latency got %0d want 1", cyc); end
    checks++; if (dout0 !== 32'h0000CAFE) begin errors++; $display("FAIL misaligned_forced got %h want 0000cafe", dout0); end
`endif
  endtask

  task automatic test_reset_mid;
    int cyc;
    start(0, 1, 0, 32'h10, 2'b10, 0, 0);
    checks++; if (mrd0 !== 1'b1) begin errors++; $display("FAIL mid_in_read got %b want 1", mrd0); end
    #2 reset_n = 0;
    #1;
    checks++; if ({busy0, done0, mrd0, mwr0, strb0} !== 8'h00) begin errors++; $display("FAIL mid_ctrl got %h want 00", {busy0, done0, mrd0, mwr0, strb0}); end
    checks++; if ({maddr0, mdo0, dout0} !== 94'h0) begin errors++; $display("FAIL mid_data got %h want 0", {maddr0, mdo0, dout0}); end
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL mid_no_done got %b want 0", done0); end
    start(0, 0, 1, 32'h04, 2'b10, 0, 32'h55667788);
    checks++; if ({mwr0, maddr0} !== {1'b1, 30'd1}) begin errors++; $display("FAIL post_reset_store got %h want 40000001", {mwr0, maddr0}); end
    finish0(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL post_reset_done got %0d want 1", cyc); end
    start(0, 1, 0, 32'h04, 2'b10, 0, 0);
    finish0(cyc);
    checks++; if (dout0 !== 32'h55667788) begin errors++; $display("FAIL post_reset_load got %h want 55667788", dout0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_wait_states;
    test_misaligned;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
